// File: rtl/phase_acc_gen.sv
// Numerically-controlled phase accumulator feeding the square-wave LUT stage.
// Produces a registered LUT address and a duty select. Tuning word and duty
// changes are double-buffered so the LUT stage never sees a torn period.
module phase_acc_gen #(
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  sync_clr,
    input  logic [DIV_WIDTH-1:0]  sample_div,
    input  logic [ACC_WIDTH-1:0]  ftw_in,
    input  logic                  ftw_load,
    input  logic [3:0]            duty_in,
    input  logic                  duty_load,
    input  logic [ADDR_WIDTH-1:0] phase_off,
    output logic [ADDR_WIDTH-1:0] phase_acc,
    output logic [3:0]            duty_cycle,
    output logic                  phase_valid,
    output logic                  wrap
);

    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
    logic [ACC_WIDTH-1:0]  ftw_active_q, ftw_active_d;
    logic [ACC_WIDTH-1:0]  ftw_pend_q, ftw_pend_d;
    logic                  ftw_pend_vld_q, ftw_pend_vld_d;
    logic [3:0]            duty_pend_q, duty_pend_d;
    logic                  duty_pend_vld_q, duty_pend_vld_d;
    logic [ADDR_WIDTH-1:0] phase_acc_q, phase_acc_d;
    logic [3:0]            duty_cycle_q, duty_cycle_d;
    logic                  phase_valid_q, phase_valid_d;
    logic                  wrap_q, wrap_d;

    logic                  clr;
    logic                  tick;
    logic [ACC_WIDTH:0]    sum;
    logic                  carry;
    logic [3:0]            duty_in_clamped;
    logic [ACC_WIDTH-1:0]  ftw_commit_val;
    logic [3:0]            duty_commit_val;

    // Decode control events and values offered at a commit point.
    always_comb begin
        clr             = enable & sync_clr;
        // sync_clr wins over a coincident tick
        tick            = enable & ~sync_clr & (div_cnt_q == sample_div);
        sum             = {1'b0, acc_q} + {1'b0, ftw_active_q};
        carry           = sum[ACC_WIDTH];
        duty_in_clamped = (duty_in > 4'd3) ? 4'd2 : duty_in;
        // A load in the committing cycle bypasses straight through
        ftw_commit_val  = ftw_load ? ftw_in :
                          (ftw_pend_vld_q ? ftw_pend_q : ftw_active_q);
        duty_commit_val = duty_load ? duty_in_clamped :
                          (duty_pend_vld_q ? duty_pend_q : duty_cycle_q);
    end

    // Next-state for accumulator, divider, buffers and outputs.
    always_comb begin
        acc_d           = acc_q;
        div_cnt_d       = div_cnt_q;
        ftw_active_d    = ftw_active_q;
        ftw_pend_d      = ftw_pend_q;
        ftw_pend_vld_d  = ftw_pend_vld_q;
        duty_pend_d     = duty_pend_q;
        duty_pend_vld_d = duty_pend_vld_q;
        phase_acc_d     = phase_acc_q;
        duty_cycle_d    = duty_cycle_q;
        phase_valid_d   = 1'b0;
        wrap_d          = 1'b0;

        // Captures into the pending registers are accepted even while disabled
        if (ftw_load) begin
            ftw_pend_d     = ftw_in;
            ftw_pend_vld_d = 1'b1;
        end
        if (duty_load) begin
            duty_pend_d     = duty_in_clamped;
            duty_pend_vld_d = 1'b1;
        end

        if (clr) begin
            acc_d           = '0;
            div_cnt_d       = '0;
            phase_acc_d     = phase_off;
            phase_valid_d   = 1'b1;
            ftw_active_d    = ftw_commit_val;
            ftw_pend_vld_d  = 1'b0;
            duty_cycle_d    = duty_commit_val;
            duty_pend_vld_d = 1'b0;
        end else if (tick) begin
            acc_d          = sum[ACC_WIDTH-1:0];
            div_cnt_d      = '0;
            phase_acc_d    = sum[ACC_WIDTH-1 -: ADDR_WIDTH] + phase_off;
            phase_valid_d  = 1'b1;
            wrap_d         = carry;
            // The addition above still uses the old tuning word
            ftw_active_d   = ftw_commit_val;
            ftw_pend_vld_d = 1'b0;
            // Duty only changes on a period boundary
            if (carry) begin
                duty_cycle_d    = duty_commit_val;
                duty_pend_vld_d = 1'b0;
            end
        end else if (enable) begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q           <= '0;
            div_cnt_q       <= '0;
            ftw_active_q    <= '0;
            ftw_pend_q      <= '0;
            ftw_pend_vld_q  <= 1'b0;
            duty_pend_q     <= 4'd2;
            duty_pend_vld_q <= 1'b0;
            phase_acc_q     <= '0;
            duty_cycle_q    <= 4'd2;
            phase_valid_q   <= 1'b0;
            wrap_q          <= 1'b0;
        end else begin
            acc_q           <= acc_d;
            div_cnt_q       <= div_cnt_d;
            ftw_active_q    <= ftw_active_d;
            ftw_pend_q      <= ftw_pend_d;
            ftw_pend_vld_q  <= ftw_pend_vld_d;
            duty_pend_q     <= duty_pend_d;
            duty_pend_vld_q <= duty_pend_vld_d;
            phase_acc_q     <= phase_acc_d;
            duty_cycle_q    <= duty_cycle_d;
            phase_valid_q   <= phase_valid_d;
            wrap_q          <= wrap_d;
        end
    end

    assign phase_acc   = phase_acc_q;
    assign duty_cycle  = duty_cycle_q;
    assign phase_valid = phase_valid_q;
    assign wrap        = wrap_q;

endmodule

// File: tb/tb_phase_acc_gen.sv
// Scoreboard bench for phase_acc_gen: a behavioural model predicts each
// phase_valid pulse; a negedge monitor pops and compares.
module tb_phase_acc_gen;

    localparam int AW = 32;
    localparam int LW = 10;
    localparam int DW = 16;
    localparam longint unsigned ACC_MOD = 64'd1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          sync_clr = 1'b0;
    logic [DW-1:0] sample_div = '0;
    logic [AW-1:0] ftw_in = '0;
    logic          ftw_load = 1'b0;
    logic [3:0]    duty_in = '0;
    logic          duty_load = 1'b0;
    logic [LW-1:0] phase_off = '0;
    logic [LW-1:0] phase_acc;
    logic [3:0]    duty_cycle;
    logic          phase_valid;
    logic          wrap;

    phase_acc_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .sync_clr   (sync_clr),
        .sample_div (sample_div),
        .ftw_in     (ftw_in),
        .ftw_load   (ftw_load),
        .duty_in    (duty_in),
        .duty_load  (duty_load),
        .phase_off  (phase_off),
        .phase_acc  (phase_acc),
        .duty_cycle (duty_cycle),
        .phase_valid(phase_valid),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int phase;
        int wrp;
        int duty;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state
    longint unsigned m_acc, m_ftw, m_ftw_pend;
    int m_div, m_phase, m_duty, m_duty_pend;
    bit m_ftw_pv, m_duty_pv;

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    endtask

    function automatic int clamp_duty(input int d);
        return (d > 3) ? 2 : d;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_ftw = 0; m_ftw_pend = 0; m_div = 0;
        m_phase = 0; m_duty = 2; m_duty_pend = 2;
        m_ftw_pv = 0; m_duty_pv = 0;
    endtask

    // Predict the effect of the upcoming rising edge from the applied inputs.
    task automatic model_step();
        exp_t e;
        longint unsigned total;
        bit carry;
        bit is_tick;
        longint unsigned new_ftw;
        int new_duty;
        is_tick  = enable && !sync_clr && (m_div == int'(sample_div));
        new_ftw  = ftw_load ? longint'(ftw_in) : (m_ftw_pv ? m_ftw_pend : m_ftw);
        new_duty = duty_load ? clamp_duty(int'(duty_in)) : (m_duty_pv ? m_duty_pend : m_duty);
        if (enable && sync_clr) begin
            m_acc = 0; m_div = 0;
            m_ftw = new_ftw; m_ftw_pv = 0;
            m_duty = new_duty; m_duty_pv = 0;
            m_phase = int'(phase_off);
            e.phase = m_phase; e.wrp = 0; e.duty = m_duty;
            exp_q.push_back(e);
            if (ftw_load) m_ftw_pend = longint'(ftw_in);
            if (duty_load) m_duty_pend = clamp_duty(int'(duty_in));
        end else if (is_tick) begin
            total   = m_acc + m_ftw;
            carry   = (total >= ACC_MOD);
            m_acc   = total % ACC_MOD;
            m_phase = int'(((m_acc >> (AW - LW)) + longint'(phase_off)) % (64'd1 << LW));
            m_div   = 0;
            m_ftw = new_ftw; m_ftw_pv = 0;
            if (ftw_load) m_ftw_pend = longint'(ftw_in);
            if (carry) begin
                m_duty = new_duty; m_duty_pv = 0;
                if (duty_load) m_duty_pend = clamp_duty(int'(duty_in));
            end else if (duty_load) begin
                m_duty_pend = clamp_duty(int'(duty_in)); m_duty_pv = 1;
            end
            e.phase = m_phase; e.wrp = int'(carry); e.duty = m_duty;
            exp_q.push_back(e);
        end else begin
            if (enable) m_div = (m_div + 1) % (1 << DW);
            if (ftw_load) begin m_ftw_pend = longint'(ftw_in); m_ftw_pv = 1; end
            if (duty_load) begin m_duty_pend = clamp_duty(int'(duty_in)); m_duty_pv = 1; end
        end
    endtask

    task automatic drive(input bit en, input bit clr, input bit fl, input logic [AW-1:0] f,
                         input bit dl, input logic [3:0] d, input logic [LW-1:0] off,
                         input logic [DW-1:0] div);
        @(negedge clk);
        #1;
        enable = en; sync_clr = clr; ftw_load = fl; ftw_in = f;
        duty_load = dl; duty_in = d; phase_off = off; sample_div = div;
        model_step();
    endtask

    task automatic idle_run(input int n, input logic [LW-1:0] off, input logic [DW-1:0] div);
        for (int i = 0; i < n; i++) drive(1, 0, 0, ftw_in, 0, duty_in, off, div);
    endtask

    // Monitor: every phase_valid pulse must match the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && phase_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("phase_acc", int'(phase_acc), e.phase);
                check("wrap", int'(wrap), e.wrp);
                check("duty_cycle", int'(duty_cycle), e.duty);
            end
        end
    end

    initial begin
        bit en, clr, fl, dl;
        logic [LW-1:0] off;
        logic [DW-1:0] div;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_phase_acc", int'(phase_acc), 0);
        check("rst_duty", int'(duty_cycle), 2);
        check("rst_valid", int'(phase_valid), 0);
        check("rst_wrap", int'(wrap), 0);
        #2 rst_n = 1'b1;

        // T2: step of one LUT address per cycle, wrap after 1024 ticks
        drive(0, 0, 1, 32'h0040_0000, 0, 4'd0, 10'd0, 16'd0);
        drive(1, 1, 0, 32'h0040_0000, 0, 4'd0, 10'd0, 16'd0);
        idle_run(1030, 10'd0, 16'd0);

        // T3: divide by four, tuning word change mid-interval
        drive(1, 1, 0, 32'h0040_0000, 0, 4'd0, 10'd0, 16'd3);
        idle_run(5, 10'd0, 16'd3);
        drive(1, 0, 1, 32'h0080_0000, 0, 4'd0, 10'd0, 16'd3);
        idle_run(40, 10'd0, 16'd3);

        // T4: duty 3 applied at wrap, then out-of-range duty clamps to 2
        drive(1, 1, 1, 32'h0040_0000, 0, 4'd0, 10'd0, 16'd0);
        idle_run(100, 10'd0, 16'd0);
        drive(1, 0, 0, 32'h0040_0000, 1, 4'd3, 10'd0, 16'd0);
        idle_run(1000, 10'd0, 16'd0);
        drive(1, 0, 0, 32'h0040_0000, 1, 4'd9, 10'd0, 16'd0);
        idle_run(1030, 10'd0, 16'd0);

        // T5: phase offset applied by sync_clr
        drive(1, 0, 0, 32'h0040_0000, 0, 4'd0, 10'd256, 16'd0);
        drive(1, 1, 0, 32'h0040_0000, 0, 4'd0, 10'd256, 16'd0);
        idle_run(20, 10'd256, 16'd0);

        // T6: freeze while disabled
        drive(1, 1, 0, 32'h0040_0000, 0, 4'd0, 10'd256, 16'd2);
        idle_run(7, 10'd256, 16'd2);
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 32'h0040_0000, 0, 4'd0, 10'd256, 16'd2);
        @(negedge clk);
        check("frozen_phase", int'(phase_acc), m_phase);
        check("frozen_valid", int'(phase_valid), 0);
        idle_run(20, 10'd256, 16'd2);

        // T1: asynchronous reset between edges
        drive(0, 0, 0, '0, 0, 4'd0, 10'd0, 16'd2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_phase_acc", int'(phase_acc), 0);
        check("midrst_duty", int'(duty_cycle), 2);
        check("midrst_valid", int'(phase_valid), 0);
        check("midrst_wrap", int'(wrap), 0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Random traffic; sample_div only changes together with sync_clr
        div = 16'd1;
        off = 10'd0;
        drive(1, 1, 0, '0, 0, 4'd0, off, div);
        for (int i = 0; i < 4000; i++) begin
            en  = ($urandom_range(0, 15) != 0);
            clr = ($urandom_range(0, 60) == 0);
            fl  = !clr && ($urandom_range(0, 20) == 0);
            dl  = !clr && ($urandom_range(0, 12) == 0);
            if (clr) div = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 30) == 0) off = 10'($urandom);
            drive(en, clr, fl, {$urandom_range(4, 127), 24'($urandom)}, dl,
                  4'($urandom), off, div);
        end
        for (int i = 0; i < 4; i++) drive(0, 0, 0, '0, 0, 4'd0, off, div);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
